instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage sitting directly upstream of `cpu`, producing the `cpu_instruction` / `cpu_instruction_RDY_BSY` pair that the core's decode consumes. It owns the program counter, issues in-order word reads to instruction memory over a request/grant/response handshake, and buffers returned words in a small prefetch queue. A redirect input flushes the queue and restarts fetch at a new PC, discarding any responses still in flight.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `DEPTH`, 2: prefetch queue entries; also the cap on queued plus outstanding requests. Power of two, ≥ 2.
- `cpu_clk` in 1: single clock; all state updates on its rising edge.
- `cpu_rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: read request valid.
- `imem_addr` out 32: word address, bits [1:0] always 0.
- `imem_gnt` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: read data valid. Responses return in request order, at least 1 cycle after grant.
- `imem_rdata` in 32: instruction word.
- `cpu_instruction` out 32: head-of-queue instruction. Reads 32'h0000_0013 (NOP) when the queue is empty.
- `cpu_instruction_RDY_BSY` out 1: high when `cpu_instruction` is valid.
- `cpu_instr_pc` out 32: PC of `cpu_instruction`.
- `cpu_instr_ack` in 1: core consumes the head. Ignored when `RDY_BSY` is 0.
- `redirect_valid` in 1: flush the queue and restart fetch.
- `redirect_pc` in 32: new PC. Bits [1:0] are forced to 0.

## Operation
- Registers:
  - `pc`: next fetch address.
  - `outstanding`: granted requests with no response yet.
  - `drop_cnt`: stale responses still to be discarded.
  - Queue of {pc, instr} entries.
  - `resp_pc`: queue of issued addresses, so each response pairs with its PC.
- Reset values: `pc`=RESET_PC, all counters 0, queue empty, `imem_req`=0, `RDY_BSY`=0, `cpu_instruction`=NOP, `cpu_instr_pc`=0.
- Request rule: `imem_req` = (outstanding + occupancy < DEPTH) and no redirect this cycle.
  - `imem_addr` = `pc`.
  - `req & gnt`: `pc` += 4 (wraps modulo 2^32) and `outstanding` increments.
- Response handling:
  - `imem_rvalid` with `drop_cnt` > 0: discard the word and decrement `drop_cnt`.
  - Otherwise: push {`resp_pc` head, `rdata`} into the queue and decrement `outstanding`.
- Consume: `RDY_BSY & cpu_instr_ack` pops the head.
  - A push and a pop in the same cycle are legal at any occupancy.
  - The credit rule guarantees the queue never overflows.
- Redirect (highest priority):
  - Queue and `resp_pc` are flushed.
  - `pc` = `redirect_pc` & ~3.
  - `drop_cnt` += `outstanding`, counting any grant and any response occurring in the same cycle correctly.
  - `outstanding` = 0.
  - A same-cycle ack is ignored.
  - A same-cycle `rvalid` is dropped.
  - Fetch resumes the next cycle. New requests may issue while `drop_cnt` > 0, since order is preserved.
- Requests stay conservative: `outstanding + drop_cnt` never exceeds 2·DEPTH. The counter width covers this value.
- `rvalid` with nothing outstanding or pending drop is a protocol error: ignored, and flagged by a simulation assertion.

## Timing
- First `imem_req`: the first cycle after `cpu_rst_n` deasserts.
- With `gnt` held at 1 and a 1-cycle response, the core sees instruction n valid 2 cycles after its request is granted.
- The queue is not bypassed: a response appears on `cpu_instruction` the cycle after `rvalid`.
- Sustained throughput is 1 instruction/cycle with `DEPTH`=2, `gnt`=1, 1-cycle response, and `ack`=1.
- `RDY_BSY` drops in the cycle after a redirect and rises again no earlier than 2 cycles after the first post-redirect grant.
- Reset asserted mid-operation clears all state immediately; memory is reset with the core.

## Structure
- Shared package `riscv_pkg` holds:
  - `XLEN` = 32
  - `NOP_INSTR` = 32'h0000_0013
  - `DEFAULT_RESET_PC`
  - instruction-word typedef
- Sub-module `sync_fifo`, parameterised on width and depth with a full/empty/count interface. It is instantiated twice:
  - 64-bit entries for the {pc, instr} queue.
  - 32-bit entries for `resp_pc`.

## Test plan
- **Reset and streaming:** hold `cpu_rst_n`=0 for 2 cycles, then release with `gnt`=1, 1-cycle memory returning `addr^32'hA5A5_0000`, `ack`=1 → requests at addresses 0,4,8,…; `cpu_instr_pc` 0,4,8 on consecutive cycles, instruction = addr^A5A5_0000.
- **Backpressure:** hold `ack`=0 → `imem_req` falls after 2 requests; `cpu_instruction` stays at pc 0. Raise `ack` → in-order delivery resumes with no gaps or duplicates.
- **Redirect with traffic in flight:** 3-cycle memory latency, `redirect_pc`=32'h0000_0103 with 2 responses outstanding → both stale responses dropped; next delivered pc = 0x100.
- **Same-cycle collision:** redirect in the same cycle as `rvalid` and `gnt` → all three are dropped/flushed as specified; first delivered pc equals the redirect target.
- **PC wrap:** `RESET_PC`=32'hFFFF_FFFC → delivered pcs FFFF_FFFC, then 0000_0000.
- **Reset during fetch:** assert `cpu_rst_n` low mid-stream → `RDY_BSY`=0 and `imem_req`=0 immediately; after release, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core-wide definitions: datapath width, canonical NOP, reset vector
// and the fetch-queue entry layout.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef logic [XLEN-1:0] instr_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    instr_t          instr;
  } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush; DEPTH must be a power of two so
// the read/write pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push, do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is accepted only when a pop frees the slot.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, issues in-order word reads under a credit
// limit, pairs responses with their PCs and feeds decode from a prefetch queue.
module instr_fetch import riscv_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 2
) (
  input  logic            cpu_clk,
  input  logic            cpu_rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output instr_t          cpu_instruction,
  output logic            cpu_instruction_RDY_BSY,
  output logic [XLEN-1:0] cpu_instr_pc,
  input  logic            cpu_instr_ack,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);
  localparam int CNT_W = $clog2(2 * DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [SUM_W-1:0] DEPTH_C     = SUM_W'(DEPTH);
  localparam logic [SUM_W-1:0] TWO_DEPTH_C = SUM_W'(2 * DEPTH);

  logic [XLEN-1:0]  pc;
  logic [CNT_W-1:0] outstanding, drop_cnt;
  logic             run_q;

  fetch_entry_t     q_wdata, q_rdata;
  logic             q_push, q_pop, q_full, q_empty;
  logic [OCC_W-1:0] q_count;
  logic [XLEN-1:0]  rp_head;
  logic             rp_full, rp_empty;
  logic [OCC_W-1:0] rp_count;

  logic             grant, rvalid_ok, resp_drop, resp_take;
  logic [SUM_W-1:0] credit_used, in_flight;

  // A pop in this cycle frees its slot for a new request, which is what
  // sustains one instruction per cycle at DEPTH=2.
  assign q_pop       = ~q_empty & cpu_instr_ack & ~redirect_valid;
  assign credit_used = SUM_W'(outstanding) + SUM_W'(q_count) - SUM_W'(q_pop);
  assign in_flight   = SUM_W'(outstanding) + SUM_W'(drop_cnt);

  assign imem_req  = run_q & ~redirect_valid & (credit_used < DEPTH_C) & (in_flight < TWO_DEPTH_C);
  assign imem_addr = pc;
  assign grant     = imem_req & imem_gnt;

  // Responses with nothing in flight are protocol errors and are ignored.
  assign rvalid_ok = imem_rvalid & ((outstanding != '0) | (drop_cnt != '0));
  assign resp_drop = rvalid_ok & (drop_cnt != '0);
  assign resp_take = rvalid_ok & (drop_cnt == '0);
  assign q_push    = resp_take & ~redirect_valid;
  assign q_wdata   = '{pc: rp_head, instr: imem_rdata};

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      run_q       <= 1'b0;
      pc          <= {RESET_PC[XLEN-1:2], 2'b00};
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      run_q <= 1'b1;
      if (redirect_valid) begin
        // Everything still in flight becomes stale; a same-cycle response
        // retires one of them whichever counter it would have hit.
        pc          <= {redirect_pc[XLEN-1:2], 2'b00};
        drop_cnt    <= drop_cnt + outstanding - CNT_W'(rvalid_ok);
        outstanding <= '0;
      end else begin
        if (grant) pc <= pc + 32'd4;
        outstanding <= outstanding + CNT_W'(grant) - CNT_W'(resp_take);
        drop_cnt    <= drop_cnt - CNT_W'(resp_drop);
      end
    end
  end

  sync_fifo #(.WIDTH(2 * XLEN), .DEPTH(DEPTH)) u_queue (
    .clk(cpu_clk), .rst_n(cpu_rst_n), .flush(redirect_valid),
    .push(q_push), .wdata(q_wdata), .pop(q_pop), .rdata(q_rdata),
    .full(q_full), .empty(q_empty), .count(q_count)
  );

  sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_resp_pc (
    .clk(cpu_clk), .rst_n(cpu_rst_n), .flush(redirect_valid),
    .push(grant), .wdata(pc), .pop(q_push), .rdata(rp_head),
    .full(rp_full), .empty(rp_empty), .count(rp_count)
  );

  logic unused_fifo_status;
  assign unused_fifo_status = ^{q_full, rp_full, rp_empty, rp_count};

  assign cpu_instruction_RDY_BSY = ~q_empty;
  assign cpu_instruction         = q_empty ? NOP_INSTR : q_rdata.instr;
  assign cpu_instr_pc            = q_empty ? '0 : q_rdata.pc;

  a_rvalid_expected: assert property (@(posedge cpu_clk) disable iff (!cpu_rst_n)
    imem_rvalid |-> ((outstanding != '0) || (drop_cnt != '0)));
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming/backpressure vectors from a table,
// then hand-written redirect, collision, wrap and reset sequences.
module tb_instr_fetch;
  logic        cpu_clk, cpu_rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] cpu_instruction, cpu_instr_pc, redirect_pc;
  logic        cpu_instruction_RDY_BSY, cpu_instr_ack, redirect_valid;

  instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .cpu_instruction(cpu_instruction), .cpu_instruction_RDY_BSY(cpu_instruction_RDY_BSY),
    .cpu_instr_pc(cpu_instr_pc), .cpu_instr_ack(cpu_instr_ack),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // clock / reset
  initial begin
    cpu_clk = 1'b0;
    forever #5 cpu_clk = ~cpu_clk;
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mem_lat = 1;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic        rst;
    logic        ack;
    logic        req;
    logic [31:0] addr;
    logic        rdy;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;
  vec_t vecs[14];

  function automatic vec_t mk(input logic rst, input logic ack, input logic req,
                              input logic [31:0] addr, input logic rdy,
                              input logic [31:0] pc, input logic [31:0] instr);
    vec_t v;
    v.rst = rst; v.ack = ack; v.req = req; v.addr = addr;
    v.rdy = rdy; v.pc = pc; v.instr = instr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: memory model presents any due response, inputs are applied,
  // outputs settle, and a grant is recorded with its return cycle.
  task automatic step(input logic ack, input logic rv, input logic [31:0] rpc);
    @(negedge cpu_clk);
    cyc++;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend_addr[0] ^ 32'hA5A5_0000;
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    cpu_instr_ack  = ack;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    if (cpu_rst_n && imem_req && imem_gnt) begin
      pend_addr.push_back(imem_addr);
      pend_due.push_back(cyc + mem_lat);
    end
  endtask

  task automatic do_reset();
    @(negedge cpu_clk);
    cpu_rst_n      = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    cpu_instr_ack  = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    pend_addr.delete();
    pend_due.delete();
    #1;
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_rdy", {31'h0, cpu_instruction_RDY_BSY}, 32'h0);
    chk("rst_instr", cpu_instruction, NOP);
    chk("rst_pc", cpu_instr_pc, 32'h0);
    repeat (2) @(negedge cpu_clk);
    cpu_rst_n = 1'b1;
    #1;
    chk("c0_req", {31'h0, imem_req}, 32'h0);
    chk("c0_addr", imem_addr, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cpu_rst_n = 1'b0; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    cpu_instr_ack = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;

    // streaming with ack=1, then a reset mid-stream and a backpressure run
    vecs[0]  = mk(1, 1, 1, 32'h00, 0, 32'h0, NOP);
    vecs[1]  = mk(0, 1, 1, 32'h04, 0, 32'h0, NOP);
    vecs[2]  = mk(0, 1, 1, 32'h08, 1, 32'h0, 32'hA5A5_0000);
    vecs[3]  = mk(0, 1, 1, 32'h0C, 1, 32'h4, 32'hA5A5_0004);
    vecs[4]  = mk(0, 1, 1, 32'h10, 1, 32'h8, 32'hA5A5_0008);
    vecs[5]  = mk(1, 0, 1, 32'h00, 0, 32'h0, NOP);
    vecs[6]  = mk(0, 0, 1, 32'h04, 0, 32'h0, NOP);
    vecs[7]  = mk(0, 0, 0, 32'h00, 1, 32'h0, 32'hA5A5_0000);
    vecs[8]  = mk(0, 0, 0, 32'h00, 1, 32'h0, 32'hA5A5_0000);
    vecs[9]  = mk(0, 0, 0, 32'h00, 1, 32'h0, 32'hA5A5_0000);
    vecs[10] = mk(0, 1, 1, 32'h08, 1, 32'h0, 32'hA5A5_0000);
    vecs[11] = mk(0, 1, 1, 32'h0C, 1, 32'h4, 32'hA5A5_0004);
    vecs[12] = mk(0, 1, 1, 32'h10, 1, 32'h8, 32'hA5A5_0008);
    vecs[13] = mk(0, 1, 1, 32'h14, 1, 32'hC, 32'hA5A5_000C);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].rst) do_reset();
      step(vecs[i].ack, 1'b0, 32'h0);
      chk($sformatf("vec%0d_req", i), {31'h0, imem_req}, {31'h0, vecs[i].req});
      if (vecs[i].req) chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].addr);
      chk($sformatf("vec%0d_rdy", i), {31'h0, cpu_instruction_RDY_BSY}, {31'h0, vecs[i].rdy});
      chk($sformatf("vec%0d_pc", i), cpu_instr_pc, vecs[i].pc);
      chk($sformatf("vec%0d_instr", i), cpu_instruction, vecs[i].instr);
    end

    // redirect with two stale responses in flight, 3-cycle memory
    do_reset();
    mem_lat = 3;
    step(1, 0, 0); chk("rd_c1_addr", imem_addr, 32'h0);
    step(1, 0, 0); chk("rd_c2_addr", imem_addr, 32'h4);
    step(1, 1, 32'h0000_0103); chk("rd_c3_req", {31'h0, imem_req}, 32'h0);
    step(1, 0, 0);
    chk("rd_c4_rdy", {31'h0, cpu_instruction_RDY_BSY}, 32'h0);
    chk("rd_c4_req", {31'h0, imem_req}, 32'h1);
    chk("rd_c4_addr", imem_addr, 32'h100);
    step(1, 0, 0); chk("rd_c5_addr", imem_addr, 32'h104);
    step(1, 0, 0); chk("rd_c6_req", {31'h0, imem_req}, 32'h0);
    chk("rd_c6_rdy", {31'h0, cpu_instruction_RDY_BSY}, 32'h0);
    step(1, 0, 0); chk("rd_c7_rdy", {31'h0, cpu_instruction_RDY_BSY}, 32'h0);
    step(1, 0, 0); chk("rd_c8_pc", cpu_instr_pc, 32'h100);
    chk("rd_c8_instr", cpu_instruction, 32'hA5A5_0100);
    step(1, 0, 0); chk("rd_c9_pc", cpu_instr_pc, 32'h104);
    chk("rd_c9_instr", cpu_instruction, 32'hA5A5_0104);

    // redirect colliding with rvalid and gnt, then a redirect to the top word
    do_reset();
    mem_lat = 1;
    repeat (3) step(1, 0, 0);
    step(1, 1, 32'h0000_0200);
    chk("co_c4_req", {31'h0, imem_req}, 32'h0);
    chk("co_c4_pc", cpu_instr_pc, 32'h4);
    step(1, 0, 0); chk("co_c5_rdy", {31'h0, cpu_instruction_RDY_BSY}, 32'h0);
    chk("co_c5_addr", imem_addr, 32'h200);
    step(1, 0, 0); chk("co_c6_rdy", {31'h0, cpu_instruction_RDY_BSY}, 32'h0);
    step(1, 0, 0); chk("co_c7_pc", cpu_instr_pc, 32'h200);
    chk("co_c7_instr", cpu_instruction, 32'hA5A5_0200);
    step(1, 1, 32'hFFFF_FFFF); chk("wr_c8_req", {31'h0, imem_req}, 32'h0);
    chk("wr_c8_pc", cpu_instr_pc, 32'h204);
    step(1, 0, 0); chk("wr_c9_rdy", {31'h0, cpu_instruction_RDY_BSY}, 32'h0);
    chk("wr_c9_addr", imem_addr, 32'hFFFF_FFFC);
    step(1, 0, 0); chk("wr_c10_req", {31'h0, imem_req}, 32'h1);
    chk("wr_c10_addr", imem_addr, 32'h0);
    step(1, 0, 0); chk("wr_c11_pc", cpu_instr_pc, 32'hFFFF_FFFC);
    chk("wr_c11_instr", cpu_instruction, 32'h5A5A_FFFC);
    step(1, 0, 0); chk("wr_c12_pc", cpu_instr_pc, 32'h0);
    chk("wr_c12_instr", cpu_instruction, 32'hA5A5_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
